// File: rtl/game_pkg.sv
// Shared constants, FSM state type and helpers for the memory game datapath.
package game_pkg;

  localparam int unsigned MAX_SLOTS = 16;
  localparam int unsigned SLOT_W    = 3;
  localparam logic [4:0]  NO_ERR    = 5'd31;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCmp,
    StResult,
    StHold
  } state_e;

  // Sequence length for a difficulty level: 4, 8, 12 or 16 slots.
  function automatic logic [4:0] seq_len(input logic [1:0] level);
    return 5'd4 + {1'b0, level, 2'b00};
  endfunction

endpackage

// File: rtl/slot_select.sv
// Combinational slot extractor: returns the SlotW-bit slot at idx_i from a packed bus.
module slot_select #(
  parameter int unsigned MaxSlots = 16,
  parameter int unsigned SlotW    = 3
) (
  input  logic [MaxSlots*SlotW-1:0]    seq_i,
  input  logic [$clog2(MaxSlots)-1:0]  idx_i,
  output logic [SlotW-1:0]             slot_o
);

  // Indexed part-select; slot k lives at bits [SlotW*k +: SlotW].
  always_comb begin
    slot_o = seq_i[idx_i*SlotW +: SlotW];
  end

endmodule

// File: rtl/answer_checker.sv
// Compares the player's entered sequence against the target pattern one slot per clock
// after the trim stage signals end of entry, and reports match count, first mismatch,
// pass/fail and a level-weighted score.
module answer_checker #(
  parameter int unsigned MAX_SLOTS   = game_pkg::MAX_SLOTS,
  parameter int unsigned SLOT_W      = game_pkg::SLOT_W,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  level,
  input  logic                        end_signal,
  input  logic [MAX_SLOTS*SLOT_W-1:0] inp_seq,
  input  logic [MAX_SLOTS*SLOT_W-1:0] pat_seq,
  input  logic                        clr,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [4:0]                  match_cnt,
  output logic [4:0]                  first_err,
  output logic [7:0]                  score
);

  import game_pkg::*;

  localparam int unsigned IdxW = $clog2(MAX_SLOTS);

  state_e                        state_q, state_d;
  logic                          end_q, end_d;
  logic                          arm_q, arm_d;
  logic [1:0]                    lvl_q, lvl_d;
  logic [MAX_SLOTS*SLOT_W-1:0]   inp_q, inp_d;
  logic [MAX_SLOTS*SLOT_W-1:0]   pat_q, pat_d;
  logic [4:0]                    n_q, n_d;
  logic [IdxW-1:0]               idx_q, idx_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          pass_q, pass_d;
  logic [4:0]                    match_cnt_q, match_cnt_d;
  logic [4:0]                    first_err_q, first_err_d;
  logic [7:0]                    score_q, score_d;

  logic [SLOT_W-1:0]             inp_slot, pat_slot;
  logic                          start;
  logic                          slot_eq;
  logic                          last_slot;

  slot_select #(
    .MaxSlots (MAX_SLOTS),
    .SlotW    (SLOT_W)
  ) u_sel_inp (
    .seq_i  (inp_q),
    .idx_i  (idx_q),
    .slot_o (inp_slot)
  );

  slot_select #(
    .MaxSlots (MAX_SLOTS),
    .SlotW    (SLOT_W)
  ) u_sel_pat (
    .seq_i  (pat_q),
    .idx_i  (idx_q),
    .slot_o (pat_slot)
  );

  // arm_q blocks a start until end_signal has been seen low, so a level that is
  // already high when reset releases is not mistaken for a rising edge.
  assign start     = end_signal & ~end_q & arm_q;
  assign slot_eq   = (inp_slot == pat_slot);
  assign last_slot = (5'(idx_q) == (n_q - 5'd1));

  // Next-state and output logic; clr has priority over everything, including start.
  always_comb begin
    state_d     = state_q;
    end_d       = end_signal;
    arm_d       = arm_q | ~end_signal;
    lvl_d       = lvl_q;
    inp_d       = inp_q;
    pat_d       = pat_q;
    n_d         = n_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    match_cnt_d = match_cnt_q;
    first_err_d = first_err_q;
    score_d     = score_q;

    if (clr) begin
      state_d     = StIdle;
      idx_d       = '0;
      busy_d      = 1'b0;
      pass_d      = 1'b0;
      match_cnt_d = 5'd0;
      first_err_d = NO_ERR;
      score_d     = 8'd0;
    end else begin
      unique case (state_q)
        StIdle, StHold: begin
          if (start) begin
            lvl_d       = level;
            inp_d       = inp_seq;
            pat_d       = pat_seq;
            idx_d       = '0;
            pass_d      = 1'b0;
            match_cnt_d = 5'd0;
            first_err_d = NO_ERR;
            state_d     = StLoad;
          end
        end
        StLoad: begin
          n_d     = seq_len(lvl_q);
          busy_d  = 1'b1;
          state_d = StCmp;
        end
        StCmp: begin
          if (slot_eq) begin
            match_cnt_d = match_cnt_q + 5'd1;
          end else if (first_err_q == NO_ERR) begin
            first_err_d = 5'(idx_q);
          end
          if (last_slot || (STOP_ON_ERR && !slot_eq)) begin
            state_d = StResult;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        StResult: begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (first_err_q == NO_ERR);
          score_d = 8'(match_cnt_q) * 8'({1'b0, lvl_q} + 3'd1);
          state_d = StHold;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      end_q       <= 1'b0;
      arm_q       <= ~end_signal;
      lvl_q       <= 2'd0;
      inp_q       <= '0;
      pat_q       <= '0;
      n_q         <= 5'd0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      match_cnt_q <= 5'd0;
      first_err_q <= NO_ERR;
      score_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      end_q       <= end_d;
      arm_q       <= arm_d;
      lvl_q       <= lvl_d;
      inp_q       <= inp_d;
      pat_q       <= pat_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      match_cnt_q <= match_cnt_d;
      first_err_q <= first_err_d;
      score_q     <= score_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign match_cnt = match_cnt_q;
  assign first_err = first_err_q;
  assign score     = score_q;

endmodule

// File: tb/tb_answer_checker.sv
// Bench for answer_checker: two instances (compare-all and stop-on-error) share stimulus;
// expected results come from a behavioural model through a scoreboard queue.
module tb_answer_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  level;
  logic        end_signal;
  logic [47:0] inp_seq;
  logic [47:0] pat_seq;
  logic        clr;

  logic        busy_a, done_a, pass_a;
  logic [4:0]  mc_a, fe_a;
  logic [7:0]  score_a;
  logic        busy_b, done_b, pass_b;
  logic [4:0]  mc_b, fe_b;
  logic [7:0]  score_b;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         lat;
    logic       pass;
    logic [4:0] mc;
    logic [4:0] fe;
    logic [7:0] score;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  answer_checker #(.MAX_SLOTS(16), .SLOT_W(3), .STOP_ON_ERR(1'b0)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .level      (level),
    .end_signal (end_signal),
    .inp_seq    (inp_seq),
    .pat_seq    (pat_seq),
    .clr        (clr),
    .busy       (busy_a),
    .done       (done_a),
    .pass       (pass_a),
    .match_cnt  (mc_a),
    .first_err  (fe_a),
    .score      (score_a)
  );

  answer_checker #(.MAX_SLOTS(16), .SLOT_W(3), .STOP_ON_ERR(1'b1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .level      (level),
    .end_signal (end_signal),
    .inp_seq    (inp_seq),
    .pat_seq    (pat_seq),
    .clr        (clr),
    .busy       (busy_b),
    .done       (done_b),
    .pass       (pass_b),
    .match_cnt  (mc_b),
    .first_err  (fe_b),
    .score      (score_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] lvl, input logic [47:0] a,
                                 input logic [47:0] b, input bit stop);
    exp_t e;
    int   n;
    int   mc;
    n     = 4 + 4 * int'(lvl);
    mc    = 0;
    e.fe  = 5'd31;
    e.lat = n + 2;
    for (int i = 0; i < n; i++) begin
      if (a[i*3 +: 3] == b[i*3 +: 3]) begin
        mc++;
      end else begin
        if (e.fe == 5'd31) e.fe = 5'(i);
        if (stop) begin
          e.lat = i + 3;
          break;
        end
      end
    end
    e.mc    = 5'(mc);
    e.pass  = (e.fe == 5'd31);
    e.score = 8'(mc * (int'(lvl) + 1));
    return e;
  endfunction

  // Raise end_signal, watch both instances for a fixed window and score the results.
  // A second end_signal edge is injected at cycle glitch_at when glitch_at > 0.
  task automatic run_check(input string tag, input int glitch_at);
    exp_t       ea, eb;
    int         lat_a, lat_b, pul_a, pul_b, bc_a, bc_b;
    logic       p_a, p_b;
    logic [4:0] m_a, m_b, f_a, f_b;
    logic [7:0] s_a, s_b;
    lat_a = -1; lat_b = -1; pul_a = 0; pul_b = 0; bc_a = 0; bc_b = 0;
    p_a = 1'bx; p_b = 1'bx; m_a = 'x; m_b = 'x; f_a = 'x; f_b = 'x; s_a = 'x; s_b = 'x;
    sb.push_back(model(level, inp_seq, pat_seq, 1'b0));
    sb.push_back(model(level, inp_seq, pat_seq, 1'b1));
    repeat (2) @(negedge clk);
    end_signal = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk);
      #1;
      if (busy_a) bc_a++;
      if (busy_b) bc_b++;
      if (done_a) begin
        pul_a++;
        if (lat_a < 0) begin
          lat_a = i; p_a = pass_a; m_a = mc_a; f_a = fe_a; s_a = score_a;
        end
      end
      if (done_b) begin
        pul_b++;
        if (lat_b < 0) begin
          lat_b = i; p_b = pass_b; m_b = mc_b; f_b = fe_b; s_b = score_b;
        end
      end
      // Inputs move after the snapshot; the running check must not see it.
      if (i == 0) begin
        inp_seq = ~inp_seq;
        pat_seq = pat_seq ^ 48'h249249249249;
        level   = ~level;
      end
      if (glitch_at > 0 && i == glitch_at) end_signal = 1'b0;
      if (glitch_at > 0 && i == glitch_at + 1) end_signal = 1'b1;
    end
    end_signal = 1'b0;
    ea = sb.pop_front();
    eb = sb.pop_front();
    chk({tag, ".a.latency"}, 32'(lat_a), 32'(ea.lat));
    chk({tag, ".a.pulses"}, 32'(pul_a), 32'd1);
    chk({tag, ".a.busy_cycles"}, 32'(bc_a), 32'(ea.lat - 1));
    chk({tag, ".a.pass"}, 32'(p_a), 32'(ea.pass));
    chk({tag, ".a.match_cnt"}, 32'(m_a), 32'(ea.mc));
    chk({tag, ".a.first_err"}, 32'(f_a), 32'(ea.fe));
    chk({tag, ".a.score"}, 32'(s_a), 32'(ea.score));
    chk({tag, ".b.latency"}, 32'(lat_b), 32'(eb.lat));
    chk({tag, ".b.pulses"}, 32'(pul_b), 32'd1);
    chk({tag, ".b.pass"}, 32'(p_b), 32'(eb.pass));
    chk({tag, ".b.match_cnt"}, 32'(m_b), 32'(eb.mc));
    chk({tag, ".b.first_err"}, 32'(f_b), 32'(eb.fe));
    chk({tag, ".b.score"}, 32'(s_b), 32'(eb.score));
    // Outputs hold in HOLD after the pulse.
    chk({tag, ".a.hold_match"}, 32'(mc_a), 32'(ea.mc));
    chk({tag, ".a.hold_pass"}, 32'(pass_a), 32'(ea.pass));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"}, 32'(busy_a), 32'd0);
    chk({tag, ".done"}, 32'(done_a), 32'd0);
    chk({tag, ".pass"}, 32'(pass_a), 32'd0);
    chk({tag, ".match_cnt"}, 32'(mc_a), 32'd0);
    chk({tag, ".first_err"}, 32'(fe_a), 32'd31);
    chk({tag, ".score"}, 32'(score_a), 32'd0);
    chk({tag, ".b.first_err"}, 32'(fe_b), 32'd31);
  endtask

  // Watches for activity that must not happen (no start accepted).
  task automatic chk_quiet(input string tag, input int cycles);
    int act;
    act = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done_a || busy_a || done_b || busy_b) act++;
    end
    chk({tag, ".no_activity"}, 32'(act), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    level      = 2'd0;
    end_signal = 1'b0;
    inp_seq    = '0;
    pat_seq    = '0;
    clr        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Level 1, all eight slots match.
    level = 2'd1;
    for (int k = 0; k < 16; k++) begin
      pat_seq[k*3 +: 3] = (k < 8) ? 3'(k) : 3'd0;
      inp_seq[k*3 +: 3] = (k < 8) ? 3'(k) : 3'd5;
    end
    run_check("lvl1_match", 0);

    // Level 3, slot 5 differs (inp 3, pat 6).
    level = 2'd3;
    for (int k = 0; k < 16; k++) begin
      pat_seq[k*3 +: 3] = 3'((k * 5 + 1) % 8);
      inp_seq[k*3 +: 3] = 3'((k * 5 + 1) % 8);
    end
    pat_seq[15 +: 3] = 3'd6;
    inp_seq[15 +: 3] = 3'd3;
    run_check("lvl3_slot5", 0);

    // Level 0, slots beyond N differ and must be ignored.
    level = 2'd0;
    for (int k = 0; k < 16; k++) begin
      pat_seq[k*3 +: 3] = 3'(k % 8);
      inp_seq[k*3 +: 3] = (k < 4) ? 3'(k % 8) : 3'((k + 1) % 8);
    end
    run_check("lvl0_unused", 0);

    // Level 2 with a second end_signal edge while comparing; it must be ignored.
    level = 2'd2;
    for (int k = 0; k < 16; k++) begin
      pat_seq[k*3 +: 3] = 3'((k * 3) % 8);
      inp_seq[k*3 +: 3] = (k == 9) ? 3'd7 : 3'((k * 3) % 8);
    end
    inp_seq[27 +: 3] = ~pat_seq[27 +: 3];
    run_check("lvl2_restart_ignored", 4);

    // clr coincident with a start edge in HOLD: clr wins, start dropped.
    @(negedge clk);
    clr        = 1'b1;
    end_signal = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk_reset_vals("clr_start");
    chk_quiet("clr_start", 20);
    end_signal = 1'b0;

    // Reset during the third CMP cycle of a level-2 check.
    level = 2'd2;
    for (int k = 0; k < 16; k++) begin
      pat_seq[k*3 +: 3] = 3'(k % 8);
      inp_seq[k*3 +: 3] = 3'(k % 8);
    end
    repeat (2) @(negedge clk);
    end_signal = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_cmp.busy", 32'(busy_a), 32'd1);
    chk("mid_cmp.match_cnt", 32'(mc_a), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("rst_mid_cmp");
    @(negedge clk);
    rst = 1'b0;
    chk_quiet("end_high_after_rst", 20);
    end_signal = 1'b0;
    run_check("lvl2_after_rst", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
